// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply accelerator: sequencer states and
// the sizing / result-indexing helpers used by the systolic array.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // A run spans 3*MAX_DIM-2 counts; keep at least one bit for degenerate sizes.
    function automatic int cnt_width(input int dim);
        int span;
        span = 3 * dim - 2;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

    function automatic int elem_idx(input int i, input int j, input int dim);
        return i * dim + j;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: signed MAC with operand forwarding registers,
// wrapping accumulator and a sticky signed-overflow flag.
module systolic_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic signed [BUS_WIDTH-1:0]  acc_o,
    output logic                         ovf_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUS_WIDTH-1:0]    addend;
    logic signed [BUS_WIDTH-1:0]    sum;
    logic                           wrap;

    assign prod   = a_i * b_i;
    assign addend = BUS_WIDTH'(prod);
    assign sum    = acc_o + addend;
    // Same-sign addends producing an opposite-sign sum means the add wrapped.
    assign wrap   = (acc_o[BUS_WIDTH-1] == addend[BUS_WIDTH-1]) &&
                    (sum[BUS_WIDTH-1] != acc_o[BUS_WIDTH-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_o   <= '0;
            b_o   <= '0;
            acc_o <= '0;
            ovf_o <= 1'b0;
        end else if (clr_i) begin
            a_o   <= '0;
            b_o   <= '0;
            acc_o <= '0;
            ovf_o <= 1'b0;
        end else if (en_i) begin
            a_o   <= a_i;
            b_o   <= b_i;
            acc_o <= sum;
            if (wrap) ovf_o <= 1'b1;
        end
    end

endmodule

// File: rtl/systolic_mac_array.sv
// MAX_DIM x MAX_DIM output-stationary systolic MAC array plus the run
// sequencer that drives the operand registers' skew counter.
module systolic_mac_array
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 8,
    localparam int MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int CNT_W     = cnt_width(MAX_DIM)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [BUS_WIDTH-1:0]                 a_vec_i,
    input  logic [BUS_WIDTH-1:0]                 b_vec_i,
    output logic [CNT_W-1:0]                     counter_o,
    output logic                                 start_bit_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] res_o,
    output logic [MAX_DIM*MAX_DIM-1:0]           ovf_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3 * MAX_DIM - 3);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             run;
    logic             clr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            counter_o <= '0;
        end else begin
            state_q   <= state_d;
            counter_o <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = counter_o;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (counter_o == LAST_CNT) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = counter_o + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign start_bit_o = run;
    assign busy_o      = run;
    assign done_o      = (state_q == ST_DONE);

    // a flows left-to-right along rows, b flows top-to-bottom along columns.
    logic signed [DATA_WIDTH-1:0] a_w [MAX_DIM][MAX_DIM+1];
    logic signed [DATA_WIDTH-1:0] b_w [MAX_DIM+1][MAX_DIM];
    logic [MAX_DIM-1:0][DATA_WIDTH-1:0] a_spill, b_spill;
    logic unused_spill;

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_edge
        assign a_w[i][0]  = a_vec_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_w[0][i]  = b_vec_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign a_spill[i] = a_w[i][MAX_DIM];
        assign b_spill[i] = b_w[MAX_DIM][i];
    end

    assign unused_spill = ^{a_spill, b_spill};

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
        for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
            localparam int IDX = elem_idx(i, j, MAX_DIM);
            systolic_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .BUS_WIDTH (BUS_WIDTH)
            ) u_pe (
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .en_i  (run),
                .clr_i (clr),
                .a_i   (a_w[i][j]),
                .b_i   (b_w[i][j]),
                .a_o   (a_w[i][j+1]),
                .b_o   (b_w[i+1][j]),
                .acc_o (res_o[IDX*BUS_WIDTH +: BUS_WIDTH]),
                .ovf_o (ovf_o[IDX])
            );
        end
    end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array (2x2): models the skewing operand
// registers and checks timing, results and overflow flags against hand values.
module tb_systolic_mac_array;

    localparam int BW = 16;
    localparam int DW = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] a_vec_i, b_vec_i;
    logic [1:0]  counter_o;
    logic        start_bit_o, busy_o, done_o;
    logic [63:0] res_o;
    logic [3:0]  ovf_o;

    int checks = 0;
    int failures = 0;
    int ma [2][2];
    int mb [2][2];

    systolic_mac_array #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .a_vec_i    (a_vec_i),
        .b_vec_i    (b_vec_i),
        .counter_o  (counter_o),
        .start_bit_o(start_bit_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .res_o      (res_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Operand registers: row r presents A[r][t-r], column c presents B[t-c][c].
    always_comb begin
        a_vec_i = '0;
        b_vec_i = '0;
        for (int r = 0; r < 2; r++) begin
            int k;
            k = int'(counter_o) - r;
            if (start_bit_o && k >= 0 && k < 2) begin
                a_vec_i[r*8 +: 8] = 8'(ma[r][k]);
                b_vec_i[r*8 +: 8] = 8'(mb[k][r]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int c00, input int c01, input int c10, input int c11);
        return {16'(c11), 16'(c10), 16'(c01), 16'(c00)};
    endfunction

    task automatic set_mats(input int a00, input int a01, input int a10, input int a11,
                            input int b00, input int b01, input int b10, input int b11);
        ma[0][0] = a00; ma[0][1] = a01; ma[1][0] = a10; ma[1][1] = a11;
        mb[0][0] = b00; mb[0][1] = b01; mb[1][0] = b10; mb[1][1] = b11;
    endtask

    // Called on a negedge; start is held across one edge, poke re-asserts it mid-run.
    task automatic run_mat(input string tag, input int poke,
                           input logic [63:0] exp_res, input logic [3:0] exp_ovf);
        int n;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_done_low"}, 64'(done_o), 64'd0);
        n = 0;
        while (busy_o && n < 20) begin
            chk({tag, "_cnt"}, 64'(counter_o), 64'(n));
            n++;
            start_i = (n == poke);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk({tag, "_busy_len"}, 64'(n), 64'd4);
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_res"}, res_o, exp_res);
        chk({tag, "_ovf"}, 64'(ovf_o), 64'(exp_ovf));
    endtask

    initial begin
        set_mats(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_res", res_o, 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_busy", 64'(busy_o), 64'd0);

        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        run_mat("basic", 0, pack4(19, 22, 43, 50), 4'h0);

        // DONE held: accepting start here is the back-to-back case.
        set_mats(-1, 2, 3, -4, 5, -6, 7, 8);
        run_mat("signed", 0, pack4(9, 22, -13, -50), 4'h0);

        set_mats(-128, -128, -128, -128, -128, -128, -128, -128);
        run_mat("ovf", 0, pack4(-32768, -32768, -32768, -32768), 4'hF);

        set_mats(1, 0, 0, 1, 1, 0, 0, 1);
        run_mat("ident", 0, pack4(1, 0, 0, 1), 4'h0);

        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        run_mat("midstart", 2, pack4(19, 22, 43, 50), 4'h0);
        @(negedge clk_i);
        chk("midstart_hold", res_o, pack4(19, 22, 43, 50));

        set_mats(-1, 2, 3, -4, 5, -6, 7, 8);
        run_mat("b2b", 0, pack4(9, 22, -13, -50), 4'h0);

        // Reset during the third RUN cycle, checked before the next edge.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("mid_busy", 64'(busy_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_cnt", 64'(counter_o), 64'd0);
        chk("arst_sbit", 64'(start_bit_o), 64'd0);
        chk("arst_res", res_o, 64'd0);
        chk("arst_ovf", 64'(ovf_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", 64'(busy_o | done_o), 64'd0);
        set_mats(1, 2, 3, 4, 5, 6, 7, 8);
        run_mat("post_rst", 0, pack4(19, 22, 43, 50), 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Downstream compute stage of the matrix-multiply accelerator. Each cycle it consumes the skewed operand vectors produced by the operand-A and operand-B registers (one element per row and column edge). It accumulates signed products in a MAX_DIM×MAX_DIM grid of processing elements and reports the result matrix with per-element overflow flags. It also owns the run sequencer: it drives the shared `counter` and `start_bit` that the operand registers use to skew their buffers.

## Interface
- `BUS_WIDTH`, 16, APB data width; also the accumulator/result element width.
- `DATA_WIDTH`, 8, operand element width (signed two's complement).
- `MAX_DIM` (local), BUS_WIDTH/DATA_WIDTH, array dimension.
- `CNT_W` (local), $clog2(3*MAX_DIM-2), counter width.

Ports:
- `clk_i`  in  1  single clock; all state updates on posedge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  run request; sampled only in IDLE or DONE.
- `a_vec_i`  in  BUS_WIDTH  operand-A buffer; element r feeds row r's left edge.
- `b_vec_i`  in  BUS_WIDTH  operand-B buffer; element c feeds column c's top edge.
- `counter_o`  out  CNT_W  skew counter to both operand registers.
- `start_bit_o`  out  1  high while RUN; enables operand buffers.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  high in DONE.
- `res_o`  out  MAX_DIM*MAX_DIM*BUS_WIDTH  C(i,j) at slice index i*MAX_DIM+j.
- `ovf_o`  out  MAX_DIM*MAX_DIM  sticky signed-overflow flag per element, same indexing.

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE/DONE with `start_i`=1: go to RUN, set `counter_o`=0, clear all accumulators, forwarding registers and `ovf_o`.
- RUN: `counter_o` increments by 1 each cycle. At `counter_o`=3*MAX_DIM-3 the next state is DONE and the counter returns to 0.
- `start_i` during RUN is ignored. A run cannot be aborted except by reset.
- DONE: hold `res_o` and `ovf_o` until the next start.
- PE(i,j) inputs:
  - a_in = row edge `a_vec_i[i]` if j=0, else the a register of PE(i,j-1).
  - b_in = column edge `b_vec_i[j]` if i=0, else the b register of PE(i-1,j).
- PE(i,j) update in RUN: acc <= acc + a_in*b_in; a_reg <= a_in; b_reg <= b_in.
  - This makes PE(i,j) see A[i][k] and B[k][j] at count t=i+j+k.
- Arithmetic: the product is signed, 2*DATA_WIDTH bits. The accumulator is a signed BUS_WIDTH value that wraps on overflow.
- Overflow rule: addends have the same sign and the sum sign differs → set the element's flag (sticky until the next start).
- Edge inputs are used only while RUN; forwarding registers are cleared on start.

## Timing
- Reset values:
  - `counter_o`, `start_bit_o`, `busy_o`, `done_o`: 0.
  - `res_o`, `ovf_o`: all 0.
  - State: IDLE.
- Start to done: RUN lasts exactly 3*MAX_DIM-2 cycles. `done_o` rises the cycle after the last RUN cycle; results are final in that same cycle.
- Operand registers respond combinationally to `counter_o`/`start_bit_o`. `a_vec_i`/`b_vec_i` are sampled in the same cycle.
- `start_i` in DONE: `done_o` falls and `busy_o` rises on the next edge (back-to-back runs, no idle gap).
- `rst_ni` low at any time: all state and outputs return to reset values immediately, independent of the clock.

## Structure
- Shared package `matmul_pkg`:
  - MAX_DIM and CNT_W derivation.
  - FSM state enum.
  - Result and flag index helper.
- Sub-module `systolic_pe`: one MAC with a and b forwarding registers, accumulator, sticky overflow and synchronous clear. Instantiated MAX_DIM² times by generate.
- Top level: FSM, counter, PE grid, output flattening.

## Test plan
All scenarios use BUS_WIDTH=16, DATA_WIDTH=8 (MAX_DIM=2). The bench models both operand registers driving skewed vectors from `counter_o`.
- Basic: A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start → `busy_o` for 4 cycles, then `done_o`; `res_o`=[19,22,43,50], `ovf_o`=0.
- Signed: A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]] → `res_o`=[9,22,-13,-50], no overflow.
- Overflow: A and B all -128 → each element 32768 wraps to -32768; all `ovf_o` bits set. Next run with A=B=identity clears the flags and gives `res_o`=[1,0,0,1].
- Start during RUN: pulse `start_i` on the 2nd RUN cycle → ignored; `done_o` still after 4 cycles with the correct result.
- Back-to-back: `start_i` held high in DONE → new RUN begins next cycle; accumulators are cleared and the second result is correct.
- Reset mid-run: drop `rst_ni` on RUN cycle 3 → outputs 0 asynchronously, state IDLE. After release, a fresh run gives the correct result.
